// File: rtl/mcdf_arbiter_if.sv
// mcdf_arbiter_if: channel and formatter bundle for mcdf_arbiter.
// Three channels (slvX_req_i/data_i/en_i/prio_i/len_i in, slvX_ack_o out),
// a formatter side (fmt_ready_i in; fmt_valid_o/data_o/id_o/sop_o/eop_o out)
// and busy_o. Modport master is the arbiter's view; slave is the environment's view.
interface mcdf_arbiter_if #(parameter int DW = 32);
  logic          slv0_req_i, slv1_req_i, slv2_req_i;
  logic [DW-1:0] slv0_data_i, slv1_data_i, slv2_data_i;
  logic          slv0_en_i, slv1_en_i, slv2_en_i;
  logic [1:0]    slv0_prio_i, slv1_prio_i, slv2_prio_i;
  logic [2:0]    slv0_len_i, slv1_len_i, slv2_len_i;
  logic          slv0_ack_o, slv1_ack_o, slv2_ack_o;
  logic          fmt_ready_i;
  logic          fmt_valid_o;
  logic [DW-1:0] fmt_data_o;
  logic [1:0]    fmt_id_o;
  logic          fmt_sop_o, fmt_eop_o;
  logic          busy_o;
  modport master (
    input  slv0_req_i, slv1_req_i, slv2_req_i,
    input  slv0_data_i, slv1_data_i, slv2_data_i,
    input  slv0_en_i, slv1_en_i, slv2_en_i,
    input  slv0_prio_i, slv1_prio_i, slv2_prio_i,
    input  slv0_len_i, slv1_len_i, slv2_len_i,
    output slv0_ack_o, slv1_ack_o, slv2_ack_o,
    input  fmt_ready_i,
    output fmt_valid_o, fmt_data_o, fmt_id_o, fmt_sop_o, fmt_eop_o, busy_o
  );
  modport slave (
    output slv0_req_i, slv1_req_i, slv2_req_i,
    output slv0_data_i, slv1_data_i, slv2_data_i,
    output slv0_en_i, slv1_en_i, slv2_en_i,
    output slv0_prio_i, slv1_prio_i, slv2_prio_i,
    output slv0_len_i, slv1_len_i, slv2_len_i,
    input  slv0_ack_o, slv1_ack_o, slv2_ack_o,
    output fmt_ready_i,
    input  fmt_valid_o, fmt_data_o, fmt_id_o, fmt_sop_o, fmt_eop_o, busy_o
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: three-channel priority burst arbiter feeding a formatter.
// Ports: clk_i, rst_i (async, active-high), bus (mcdf_arbiter_if.master).
// Define MCDF_ARB_RR_EN for round-robin resolution of equal-priority ties;
// otherwise ties go to the lowest channel index.
module mcdf_arbiter #(parameter int DW = 32) (
  input logic           clk_i,
  input logic           rst_i,
  mcdf_arbiter_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2;
  logic [1:0]    state, gnt, win, best, start, idx;
  logic [2:0]    cnt, req, elig, s;
  logic          first, found, xfer, valid, beat;
  logic [1:0]    prio [3];
  logic [2:0]    len [3];
  logic [DW-1:0] data [3];
  assign req     = {bus.slv2_req_i, bus.slv1_req_i, bus.slv0_req_i};
  assign elig    = req & {bus.slv2_en_i, bus.slv1_en_i, bus.slv0_en_i};
  assign prio[0] = bus.slv0_prio_i;
  assign prio[1] = bus.slv1_prio_i;
  assign prio[2] = bus.slv2_prio_i;
  assign len[0]  = bus.slv0_len_i;
  assign len[1]  = bus.slv1_len_i;
  assign len[2]  = bus.slv2_len_i;
  assign data[0] = bus.slv0_data_i;
  assign data[1] = bus.slv1_data_i;
  assign data[2] = bus.slv2_data_i;
`ifdef MCDF_ARB_RR_EN
  logic [1:0] ptr;
  // Scan begins just after the last grantee so a strict '<' favours it on ties.
  assign start = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr <= 2'd2;
    else if (state == ARB && |elig) ptr <= win;
`else
  assign start = 2'd0;
`endif
  always_comb begin
    win   = 2'd0;
    best  = 2'd3;
    found = 1'b0;
    s     = 3'd0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      s   = {1'b0, start} + 3'(k);
      idx = (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
      if (elig[idx] && (!found || prio[idx] < best)) begin
        win   = idx;
        best  = prio[idx];
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 3'd0;
      gnt   <= 2'd0;
      first <= 1'b0;
    end else
      case (state)
        IDLE: if (|elig) state <= ARB;
        ARB:
          if (|elig) begin
            gnt   <= win;
            cnt   <= len[win];
            first <= 1'b1;
            state <= XFER;
          end else state <= IDLE;
        XFER:
          if (beat) begin
            first <= 1'b0;
            if (cnt == 3'd0) state <= IDLE;
            else cnt <= cnt - 3'd1;
          end
        default: state <= IDLE;
      endcase
  // Gating with rst_i keeps every output quiet within the reset cycle itself.
  assign xfer            = state == XFER && !rst_i;
  assign valid           = xfer && req[gnt];
  assign beat            = valid && bus.fmt_ready_i;
  assign bus.fmt_valid_o = valid;
  assign bus.fmt_data_o  = xfer ? data[gnt] : '0;
  assign bus.fmt_id_o    = gnt;
  assign bus.fmt_sop_o   = valid && first;
  assign bus.fmt_eop_o   = valid && cnt == 3'd0;
  assign {bus.slv2_ack_o, bus.slv1_ack_o, bus.slv0_ack_o} = {3{beat}} & (3'b001 << gnt);
  assign bus.busy_o      = state != IDLE && !rst_i;
endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: scoreboard bench for mcdf_arbiter against a burst-level reference model.
module tb_mcdf_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mcdf_arbiter_if #(.DW(32)) bus();
  mcdf_arbiter #(.DW(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  typedef struct packed {
    logic        busy, valid, sop, eop;
    logic [1:0]  id;
    logic [2:0]  ack;
    logic [31:0] data;
  } obs_t;
  obs_t q[$];
  int checks = 0, errors = 0;
  int ph = 0, g = 0, cnt = 0, ptr = 2;
  bit first = 0;
  bit [2:0] req, en;
  int pr[3], ln[3];
  logic [31:0] dat[3];
  bit ready;
  function automatic int rank(int i);
`ifdef MCDF_ARB_RR_EN
    return (i - ptr + 5) % 3;
`else
    return i;
`endif
  endfunction
  function automatic int pick();
    int w = -1, bk = 1000;
    for (int i = 0; i < 3; i++)
      if (req[i] && en[i] && pr[i] * 3 + rank(i) < bk) begin
        bk = pr[i] * 3 + rank(i);
        w  = i;
      end
    return w;
  endfunction
  function automatic void chk(string n, logic [31:0] a, logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, b, $time);
    end
  endfunction
  task automatic cyc(input bit r, input bit [2:0] rq, input bit [2:0] e,
                     input int p0, input int p1, input int p2,
                     input int l0, input int l1, input int l2, input bit rd);
    obs_t x;
    @(negedge clk);
    rst = r; req = rq; en = e; ready = rd;
    pr = '{p0, p1, p2};
    ln = '{l0, l1, l2};
    for (int i = 0; i < 3; i++) dat[i] = $urandom;
    bus.slv0_req_i = req[0]; bus.slv1_req_i = req[1]; bus.slv2_req_i = req[2];
    bus.slv0_en_i = en[0]; bus.slv1_en_i = en[1]; bus.slv2_en_i = en[2];
    bus.slv0_prio_i = 2'(p0); bus.slv1_prio_i = 2'(p1); bus.slv2_prio_i = 2'(p2);
    bus.slv0_len_i = 3'(l0); bus.slv1_len_i = 3'(l1); bus.slv2_len_i = 3'(l2);
    bus.slv0_data_i = dat[0]; bus.slv1_data_i = dat[1]; bus.slv2_data_i = dat[2];
    bus.fmt_ready_i = ready;
    x = '0;
    if (r) begin
      ph = 0; g = 0; cnt = 0; ptr = 2; first = 0;
    end else if (ph == 0) begin
      if (|(req & en)) ph = 1;
    end else if (ph == 1) begin
      x.busy = 1;
      if (|(req & en)) begin
        g = pick(); cnt = ln[g]; first = 1; ptr = g; ph = 2;
      end else ph = 0;
    end else begin
      x.busy  = 1;
      x.id    = 2'(g);
      x.data  = dat[g];
      x.valid = req[g];
      x.sop   = x.valid && first;
      x.eop   = x.valid && cnt == 0;
      if (x.valid && ready) begin
        x.ack = 3'(1 << g);
        first = 0;
        if (cnt == 0) ph = 0;
        else cnt--;
      end
    end
    #1 q.push_back(x);
  endtask
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard empty at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("busy", 32'(bus.busy_o), 32'(e.busy));
        chk("valid", 32'(bus.fmt_valid_o), 32'(e.valid));
        chk("ack", 32'({bus.slv2_ack_o, bus.slv1_ack_o, bus.slv0_ack_o}), 32'(e.ack));
        chk("data", bus.fmt_data_o, e.data);
        chk("sop", 32'(bus.fmt_sop_o), 32'(e.sop));
        chk("eop", 32'(bus.fmt_eop_o), 32'(e.eop));
        if (e.valid) chk("id", 32'(bus.fmt_id_o), 32'(e.id));
      end
    end
  end
  initial begin
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (8) cyc(0, 3'b010, 3'b010, 0, 2, 0, 0, 3, 0, 1);
    repeat (8) cyc(0, 3'b101, 3'b101, 3, 0, 0, 0, 0, 0, 1);
    repeat (12) cyc(0, 3'b111, 3'b111, 1, 1, 1, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) cyc(0, 3'b001, 3'b001, 0, 0, 0, 7, 0, 0, !(i >= 6 && i < 9));
    repeat (3) cyc(0, 3'b010, 3'b010, 0, 0, 0, 0, 5, 0, 1);
    cyc(1, 3'b010, 3'b010, 0, 0, 0, 0, 5, 0, 1);
    repeat (10) cyc(0, 3'b010, 3'b010, 0, 0, 0, 0, 5, 0, 1);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(99) == 0,
          {$urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0},
          {$urandom_range(7) != 0, $urandom_range(7) != 0, $urandom_range(7) != 0},
          $urandom_range(3), $urandom_range(3), $urandom_range(3),
          $urandom_range(7), $urandom_range(7), $urandom_range(7),
          $urandom_range(3) != 0);
    #3;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
